// File: rtl/lut_tri_state_driver_if.sv
// Control and status bundle between local decode logic and the LUT tri-state driver.
// The tri-state output S stays a plain port on the driver so that it resolves as an ordinary bus net.
interface lut_tri_state_driver_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
);
  logic [N_IN-1:0] E;
  logic            HOLD;
  logic            nCS;
  logic            drv;
  logic            busy;

  modport master (output E, output HOLD, output nCS, input drv, input busy);
  modport slave  (input E, input HOLD, input nCS, output drv, output busy);
endinterface

// File: rtl/lut_tri_state_driver.sv
// Registered LUT function whose outputs drive a shared bus through a tri-state buffer.
// A turnaround FSM inserts an arm delay before driving and a guard gap after release.
module lut_tri_state_driver #(
  parameter int N_IN      = 3,
  parameter int N_OUT     = 2,
  parameter     LUT       = 16'hA918,
  parameter int ARM_CYC   = 2,
  parameter int GUARD_CYC = 1
) (
  input  logic                  clk,
  input  logic                  nRST,
  lut_tri_state_driver_if.slave bus,
  output logic [N_OUT-1:0]      S
);

  localparam int DEPTH   = 2 ** N_IN;
  localparam int LUT_W   = N_OUT * DEPTH;
  localparam int CNT_MAX = (ARM_CYC > GUARD_CYC) ? ARM_CYC : GUARD_CYC;
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  // Elaboration-time parameter range checks.
  if (N_IN < 1 || N_IN > 8) begin : gBadNIn
    $error("lut_tri_state_driver: N_IN out of range 1..8");
  end
  if (N_OUT < 1 || N_OUT > 16) begin : gBadNOut
    $error("lut_tri_state_driver: N_OUT out of range 1..16");
  end
  if (ARM_CYC < 0 || ARM_CYC > 255) begin : gBadArm
    $error("lut_tri_state_driver: ARM_CYC out of range 0..255");
  end
  if (GUARD_CYC < 0 || GUARD_CYC > 255) begin : gBadGuard
    $error("lut_tri_state_driver: GUARD_CYC out of range 0..255");
  end
  if ($bits(LUT) != LUT_W) begin : gBadLut
    $error("lut_tri_state_driver: LUT width must be N_OUT*2**N_IN");
  end

  // Row k holds output k for every input combination: bit k*DEPTH+E of LUT.
  localparam logic [N_OUT-1:0][DEPTH-1:0] LUT_TAB = LUT_W'(LUT);

  typedef enum logic [1:0] {
    HIZ   = 2'd0,
    ARM   = 2'd1,
    DRIVE = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            drvQ;
  logic            busyQ;
  logic [N_OUT-1:0] sReg;
  logic [N_OUT-1:0] lutOut;

  for (genvar k = 0; k < N_OUT; k++) begin : gLut
    assign lutOut[k] = LUT_TAB[k][bus.E];
  end

  // Output register: follows the LUT every cycle unless frozen by HOLD.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sReg <= '0;
    end else if (!bus.HOLD) begin
      sReg <= lutOut;
    end
  end

  // Turnaround FSM with registered drv/busy decoded from the next state.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= HIZ;
      cnt   <= '0;
      drvQ  <= 1'b0;
      busyQ <= 1'b0;
    end else begin
      case (state)
        HIZ: begin
          if (!bus.nCS) begin
            if (ARM_CYC == 0) begin
              state <= DRIVE;
              drvQ  <= 1'b1;
            end else begin
              state <= ARM;
              cnt   <= CW'(ARM_CYC - 1);
              busyQ <= 1'b1;
            end
          end
        end
        ARM: begin
          if (bus.nCS) begin
            state <= HIZ;
            busyQ <= 1'b0;
          end else if (cnt == '0) begin
            state <= DRIVE;
            busyQ <= 1'b0;
            drvQ  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DRIVE: begin
          if (bus.nCS) begin
            drvQ <= 1'b0;
            if (GUARD_CYC == 0) begin
              state <= HIZ;
            end else begin
              state <= GUARD;
              cnt   <= CW'(GUARD_CYC - 1);
              busyQ <= 1'b1;
            end
          end
        end
        GUARD: begin
          // The last guard edge behaves as HIZ so a held select is honoured at t+GUARD_CYC.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!bus.nCS) begin
            if (ARM_CYC == 0) begin
              state <= DRIVE;
              busyQ <= 1'b0;
              drvQ  <= 1'b1;
            end else begin
              state <= ARM;
              cnt   <= CW'(ARM_CYC - 1);
            end
          end else begin
            state <= HIZ;
            busyQ <= 1'b0;
          end
        end
        default: begin
          state <= HIZ;
          cnt   <= '0;
          drvQ  <= 1'b0;
          busyQ <= 1'b0;
        end
      endcase
    end
  end

  assign bus.drv  = drvQ;
  assign bus.busy = busyQ;
  assign S        = drvQ ? sReg : 'z;

endmodule

// File: tb/tb_lut_tri_state_driver.sv
// Directed test of the LUT tri-state driver with default parameters.
module tb_lut_tri_state_driver;

  logic       clk;
  logic       nRST;
  logic [1:0] S;

  int nChecks;
  int nErrors;

  // {S[1],S[0]} for E = 0..7 with LUT 16'hA918, worked out bit by bit.
  logic [1:0] expTab [8];

  lut_tri_state_driver_if #(.N_IN(3), .N_OUT(2)) bus ();

  lut_tri_state_driver #(
    .N_IN(3),
    .N_OUT(2),
    .LUT(16'hA918),
    .ARM_CYC(2),
    .GUARD_CYC(1)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .bus(bus),
    .S(S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    expTab[0] = 2'b10; expTab[1] = 2'b00; expTab[2] = 2'b00; expTab[3] = 2'b11;
    expTab[4] = 2'b01; expTab[5] = 2'b10; expTab[6] = 2'b00; expTab[7] = 2'b10;

    nRST     = 1'b0;
    bus.nCS  = 1'b1;
    bus.HOLD = 1'b0;
    bus.E    = 3'd0;

    // 1: reset, then idle with nCS high
    repeat (3) tick();
    checkVal("rst_drv", 32'(bus.drv), 32'd0);
    checkVal("rst_busy", 32'(bus.busy), 32'd0);
    nRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkVal("idle_drv", 32'(bus.drv), 32'd0);
      checkVal("idle_busy", 32'(bus.busy), 32'd0);
    end

    // 2: select with E=011, driven from edge 2
    bus.E   = 3'b011;
    bus.nCS = 1'b0;
    tick();
    checkVal("arm0_busy", 32'(bus.busy), 32'd1);
    checkVal("arm0_drv", 32'(bus.drv), 32'd0);
    tick();
    checkVal("arm1_busy", 32'(bus.busy), 32'd1);
    checkVal("arm1_drv", 32'(bus.drv), 32'd0);
    tick();
    checkVal("drive_drv", 32'(bus.drv), 32'd1);
    checkVal("drive_busy", 32'(bus.busy), 32'd0);
    checkVal("drive_S", 32'(S), 32'b11);

    // 3: sweep E while driving
    for (int e = 0; e < 8; e++) begin
      bus.E = 3'(e);
      tick();
      checkVal("sweep_S", 32'(S), 32'(expTab[e]));
    end

    // 4: release for one edge, then reselect during guard
    bus.nCS = 1'b1;
    tick();
    checkVal("rel_drv", 32'(bus.drv), 32'd0);
    checkVal("rel_busy", 32'(bus.busy), 32'd1);
    bus.nCS = 1'b0;
    tick();
    checkVal("rearm_busy", 32'(bus.busy), 32'd1);
    checkVal("rearm_drv", 32'(bus.drv), 32'd0);
    tick();
    checkVal("rearm2_drv", 32'(bus.drv), 32'd0);
    tick();
    checkVal("redrive_drv", 32'(bus.drv), 32'd1);
    checkVal("redrive_S", 32'(S), 32'b10);

    // 5: release fully, then a one-cycle select that aborts in ARM
    bus.nCS = 1'b1;
    tick();
    tick();
    checkVal("hiz_busy", 32'(bus.busy), 32'd0);
    bus.nCS = 1'b0;
    tick();
    checkVal("abort_arm_busy", 32'(bus.busy), 32'd1);
    bus.nCS = 1'b1;
    tick();
    checkVal("abort_busy", 32'(bus.busy), 32'd0);
    checkVal("abort_drv", 32'(bus.drv), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal("abort_idle_drv", 32'(bus.drv), 32'd0);
    end

    // 6: HOLD freezes output, async reset mid-DRIVE
    bus.E   = 3'b011;
    bus.nCS = 1'b0;
    repeat (3) tick();
    checkVal("hold_pre_S", 32'(S), 32'b11);
    bus.HOLD = 1'b1;
    bus.E    = 3'b000;
    tick();
    checkVal("hold_S", 32'(S), 32'b11);
    tick();
    checkVal("hold2_S", 32'(S), 32'b11);
    #2;
    nRST = 1'b0;
    #1;
    checkVal("async_drv", 32'(bus.drv), 32'd0);
    checkVal("async_busy", 32'(bus.busy), 32'd0);
    tick();
    // Output register must have cleared: keep HOLD so it stays 0 until driven again.
    nRST = 1'b1;
    bus.E = 3'b011;
    repeat (3) tick();
    checkVal("post_rst_drv", 32'(bus.drv), 32'd1);
    checkVal("post_rst_S", 32'(S), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
